// File: rtl/inst_mem_resp.sv
// Instruction memory responder: a program-load write port plus a fixed-latency
// fetch port driven by an IDLE/WAIT/RESP state machine.
module inst_mem_resp #(
    parameter int NPC   = 6,
    parameter int NINST = 32,
    parameter int WAIT  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [NPC-1:0]   i_addr,
    output logic             o_ready,
    output logic             o_inst_valid,
    output logic [NINST-1:0] o_inst,
    input  logic             i_wr_en,
    input  logic [NPC-1:0]   i_wr_addr,
    input  logic [NINST-1:0] i_wr_data
);

    localparam int DEPTH = 2 ** NPC;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic [NPC-1:0]   addr_q;
    logic [NINST-1:0] mem [DEPTH];

    // Storage has no reset so it survives a mid-access reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read below samples mem before this edge's write lands, so a
    // same-edge write to the captured address is not seen in the response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            o_ready      <= 1'b1;
            o_inst_valid <= 1'b0;
            o_inst       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_ce) begin
                        state   <= S_WAIT;
                        cnt     <= CNT_LOAD;
                        addr_q  <= i_addr;
                        o_ready <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state        <= S_RESP;
                        o_inst       <= mem[addr_q];
                        o_inst_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state        <= S_IDLE;
                    o_inst_valid <= 1'b0;
                    o_ready      <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    o_inst_valid <= 1'b0;
                    o_ready      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: three instances (WAIT=2, 1, 15) share
// stimulus; index 0 is the main WAIT=2 device.
module tb_inst_mem_resp;

    localparam int NPC   = 6;
    localparam int NINST = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ce = 1'b0;
    logic [NPC-1:0]   addr = '0;
    logic             wr_en = 1'b0;
    logic [NPC-1:0]   wr_addr = '0;
    logic [NINST-1:0] wr_data = '0;

    logic             rdy  [3];
    logic             vld  [3];
    logic [NINST-1:0] inst [3];
    int               waits [3] = '{2, 1, 15};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_mem_resp #(.NPC(NPC), .NINST(NINST), .WAIT(2)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr),
        .o_ready(rdy[0]), .o_inst_valid(vld[0]), .o_inst(inst[0]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    inst_mem_resp #(.NPC(NPC), .NINST(NINST), .WAIT(1)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr),
        .o_ready(rdy[1]), .o_inst_valid(vld[1]), .o_inst(inst[1]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    inst_mem_resp #(.NPC(NPC), .NINST(NINST), .WAIT(15)) u_w15 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_addr(addr),
        .o_ready(rdy[2]), .o_inst_valid(vld[2]), .o_inst(inst[2]),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
    );

    task automatic check(input string tag, input logic [NINST-1:0] obs,
                         input logic [NINST-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [NPC-1:0] a, input logic [NINST-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request to all instances; each must pulse valid exactly once,
    // WAIT edges after the accept edge, with the expected word.
    task automatic fetch(input string tag, input logic [NPC-1:0] a,
                         input logic [NINST-1:0] exp);
        int first [3];
        int pulses [3];
        logic [NINST-1:0] got [3];
        for (int i = 0; i < 3; i++) begin
            first[i] = -1; pulses[i] = 0; got[i] = '0;
        end
        @(negedge clk);
        ce = 1'b1; addr = a;
        @(posedge clk); #1;
        ce = 1'b0; addr = ~a;
        check({tag, " ready_low_after_accept"}, 32'(rdy[0]), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] === 1'b1) begin
                    pulses[i]++;
                    if (first[i] < 0) begin
                        first[i] = k;
                        got[i]   = inst[i];
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s w%0d latency", tag, waits[i]), 32'(first[i]), 32'(waits[i]));
            check($sformatf("%s w%0d pulses", tag, waits[i]), 32'(pulses[i]), 32'd1);
            check($sformatf("%s w%0d data", tag, waits[i]), got[i], exp);
        end
    endtask

    initial begin
        int stray;

        // Asynchronous reset takes effect without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset ready", 32'(rdy[0]), 32'd1);
        check("reset valid", 32'(vld[0]), 32'd0);
        check("reset inst", inst[0], 32'd0);
        idle(2);
        @(negedge clk) rst = 1'b0;

        // Load and fetch.
        wr(6'd5, 32'h3C01_0101);
        fetch("load_fetch", 6'd5, 32'h3C01_0101);

        wr(6'd0,  32'hD000_0000);
        wr(6'd1,  32'hD000_0001);
        wr(6'd2,  32'hD000_0002);
        wr(6'd7,  32'h1111_1111);
        wr(6'd63, 32'hA5A5_0063);
        wr(6'd62, 32'h5A5A_0062);

        // Held i_ce with changing address: only the accepted address is served.
        @(negedge clk); ce = 1'b1; addr = 6'd0;
        @(posedge clk); #1;
        check("ign ready N", 32'(rdy[0]), 32'd0);
        @(negedge clk); addr = 6'd1;
        @(posedge clk); #1;
        check("ign ready N+1", 32'(rdy[0]), 32'd0);
        check("ign valid N+1", 32'(vld[0]), 32'd0);
        @(negedge clk); addr = 6'd2;
        @(posedge clk); #1;
        check("ign ready N+2", 32'(rdy[0]), 32'd0);
        check("ign valid N+2", 32'(vld[0]), 32'd1);
        check("ign data N+2", inst[0], 32'hD000_0000);
        @(posedge clk); #1;
        check("ign ready N+3", 32'(rdy[0]), 32'd1);
        check("ign valid N+3", 32'(vld[0]), 32'd0);
        check("ign hold N+3", inst[0], 32'hD000_0000);
        @(posedge clk); #1;
        check("ign reaccept N+4", 32'(rdy[0]), 32'd0);
        @(negedge clk); ce = 1'b0;
        idle(2);
        check("ign second valid", 32'(vld[0]), 32'd1);
        check("ign second data", inst[0], 32'hD000_0002);
        idle(20);

        // Same-edge write to the pending address is not visible.
        @(negedge clk); ce = 1'b1; addr = 6'd7;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'h2222_2222;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("collision valid", 32'(vld[0]), 32'd1);
        check("collision old data", inst[0], 32'h1111_1111);
        idle(20);
        fetch("collision_repeat", 6'd7, 32'h2222_2222);

        // Reset during WAIT abandons the request; memory survives.
        @(negedge clk); ce = 1'b1; addr = 6'd5;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst ready", 32'(rdy[0]), 32'd1);
        check("midrst valid", 32'(vld[0]), 32'd0);
        check("midrst inst", inst[0], 32'd0);
        @(negedge clk) rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (vld[i] !== 1'b0) stray++;
        end
        check("midrst no stray valid", 32'(stray), 32'd0);
        fetch("midrst_refetch", 6'd5, 32'h3C01_0101);

        // First edge after reset release accepts a request.
        @(negedge clk) rst = 1'b1;
        @(negedge clk); rst = 1'b0; ce = 1'b1; addr = 6'd62;
        @(posedge clk); #1;
        ce = 1'b0;
        check("first_edge accept", 32'(rdy[0]), 32'd0);
        idle(2);
        check("first_edge data", inst[0], 32'h5A5A_0062);
        idle(20);

        // Top address, and the bottom address is not aliased by it.
        fetch("addr63", 6'd63, 32'hA5A5_0063);
        fetch("addr0", 6'd0, 32'hD000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
